// File: rtl/cosine_pkg.sv
// cosine_pkg: definitions shared by the vector loader, its bus interface and
// the similarity engine wired beside it.
//   FP32_W  - width of one FP32 element / result word
//   state_e - loader FSM state encoding
//   cnt_w   - counter width helper (never narrower than one bit)
package cosine_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Bits needed to count 0..n-1; a one-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cosine_vec_loader_if.sv
// cosine_vec_loader_if: bundles the loader's element stream, engine link and
// result handshake.
//   in_valid/in_ready/in_data            - upstream FP32 element stream
//   vec_a/vec_b/start                    - vectors and trigger to the engine
//   sim_valid/sim_similarity             - engine result strobe and value
//   res_valid/res_ready/res_data/res_err - result handshake to downstream
// Modports: slave = the loader itself, master = the surrounding environment.
interface cosine_vec_loader_if
  import cosine_pkg::*;
#(
  parameter int W = 5
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [FP32_W-1:0]        in_data;
  logic [W-1:0][FP32_W-1:0] vec_a;
  logic [W-1:0][FP32_W-1:0] vec_b;
  logic                     start;
  logic                     sim_valid;
  logic [FP32_W-1:0]        sim_similarity;
  logic                     res_valid;
  logic                     res_ready;
  logic [FP32_W-1:0]        res_data;
  logic                     res_err;

  modport slave (
    input  in_valid, in_data, sim_valid, sim_similarity, res_ready,
    output in_ready, vec_a, vec_b, start, res_valid, res_data, res_err
  );

  modport master (
    output in_valid, in_data, sim_valid, sim_similarity, res_ready,
    input  in_ready, vec_a, vec_b, start, res_valid, res_data, res_err
  );

endinterface

// File: rtl/cosine_vec_loader.sv
// cosine_vec_loader: collects 2*W FP32 elements (a[0..W-1] then b[0..W-1])
// into registered vectors, pulses start for the similarity engine, waits for
// its result under a watchdog and presents the result (or a timeout error)
// downstream with a valid/ready handshake.
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   flush - synchronous abort back to LOAD; keeps vectors and res_data
//   bus   - cosine_vec_loader_if.slave (element stream, engine link, result)
// Parameters: W elements per vector, TIMEOUT maximum WAIT cycles.
module cosine_vec_loader
  import cosine_pkg::*;
#(
  parameter int W       = 5,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  cosine_vec_loader_if.slave bus
);

  localparam int K_W  = cnt_w(2 * W);
  localparam int WD_W = cnt_w(TIMEOUT);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(2 * W - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [W-1:0][FP32_W-1:0] vec_a_q, vec_a_d;
  logic [W-1:0][FP32_W-1:0] vec_b_q, vec_b_d;
  logic                     start_q, start_d;
  logic                     res_valid_q, res_valid_d;
  logic [FP32_W-1:0]        res_data_q, res_data_d;
  logic                     res_err_q, res_err_d;
  logic                     in_ready_s;
  logic                     in_hs_s;

  // Ready is combinational so a flush blocks the element arriving with it.
  assign in_ready_s = (state_q == ST_LOAD) && !flush;
  assign in_hs_s    = bus.in_valid && in_ready_s;

  // Next-state, element steering, watchdog and result capture.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wd_d       = wd_q;
    vec_a_d    = vec_a_q;
    vec_b_d    = vec_b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    if (flush) begin
      // Abort wins over everything; vectors and res_data deliberately kept.
      state_d = ST_LOAD;
      k_d     = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs_s) begin
            // Element k lands in a[k] for k<W, otherwise in b[k-W].
            for (int i = 0; i < W; i++) begin
              if (k_q == K_W'(i)) begin
                vec_a_d[i] = bus.in_data;
              end else begin
                vec_a_d[i] = vec_a_q[i];
              end
              if (k_q == K_W'(i + W)) begin
                vec_b_d[i] = bus.in_data;
              end else begin
                vec_b_d[i] = vec_b_q[i];
              end
            end
            if (k_q == K_LAST) begin
              k_d     = '0;
              state_d = ST_START;
            end else begin
              k_d     = k_q + K_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_START: begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the timeout cycle still counts as success.
          if (bus.sim_valid) begin
            res_data_d = bus.sim_similarity;
            res_err_d  = 1'b0;
            state_d    = ST_OUT;
          end else if (wd_q == WD_LAST) begin
            res_data_d = {FP32_W{1'b0}};
            res_err_d  = 1'b1;
            state_d    = ST_OUT;
          end else begin
            wd_d    = wd_q + WD_W'(1);
            state_d = ST_WAIT;
          end
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_OUT;
          end
        end
        default: begin
          state_d = ST_LOAD;
          k_d     = '0;
          wd_d    = '0;
        end
      endcase
    end

    // Registered strobes follow the state they belong to.
    start_d     = (state_d == ST_START);
    res_valid_d = (state_d == ST_OUT);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      wd_q        <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {FP32_W{1'b0}};
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.vec_a     = vec_a_q;
  assign bus.vec_b     = vec_b_q;
  assign bus.start     = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// tb_cosine_vec_loader: randomized self-checking bench for cosine_vec_loader.
// The engine is modelled by the bench driving sim_valid at a chosen delay;
// expected vectors come from an array model filled by the a-then-b rule.
module tb_cosine_vec_loader;
  import cosine_pkg::*;

  localparam int W       = 5;
  localparam int TIMEOUT = 64;

  typedef logic [W-1:0][31:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  cosine_vec_loader_if #(.W(W)) bus ();

  cosine_vec_loader #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  logic [31:0] stim  [2*W];
  logic [31:0] mdl_a [W];
  logic [31:0] mdl_b [W];

  // Count start pulses on the edge that consumes them.
  always @(posedge clk) if (bus.start === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t exp_vec(input bit sel_b);
    vec_t v;
    for (int i = 0; i < W; i++) v[i] = sel_b ? mdl_b[i] : mdl_a[i];
    return v;
  endfunction

  task automatic new_stim();
    for (int i = 0; i < 2*W; i++) stim[i] = $urandom;
  endtask

  // Drive the first n stimulus elements; the model follows the a-then-b rule.
  task automatic feed(input int n, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < g; j++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      tick();
      if (i < W) mdl_a[i] = stim[i];
      else       mdl_b[i-W] = stim[i];
    end
    bus.in_valid = 1'b0;
  endtask

  // Called in the start cycle; engine answers d cycles after start if use_resp.
  task automatic await_result(input int d, input bit use_resp,
                              input logic [31:0] val, output int lat);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 200) begin
      if (lat == 0) begin
        bus.sim_valid      = 1'b1;        // start cycle: must be ignored
        bus.sim_similarity = $urandom;
      end else if (use_resp && lat == d) begin
        bus.sim_valid      = 1'b1;
        bus.sim_similarity = val;
      end else begin
        bus.sim_valid      = 1'b0;
        bus.sim_similarity = $urandom;
      end
      tick();
      lat++;
    end
    bus.sim_valid = 1'b0;
  endtask

  // Hold the result for r cycles under noise, then accept it.
  task automatic drain(input int r, input logic [31:0] ed, input logic ee);
    vec_t ea, eb;
    ea = exp_vec(1'b0);
    eb = exp_vec(1'b1);
    bus.res_ready = 1'b0;
    for (int j = 0; j < r; j++) begin
      bus.in_valid       = 1'($urandom_range(0, 1));
      bus.in_data        = $urandom;
      bus.sim_valid      = 1'($urandom_range(0, 1));
      bus.sim_similarity = $urandom;
      #1;
      vectors++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== ed || bus.res_err !== ee) begin
        miscompares++;
        $display("FAIL hold_result: valid=%b data=%h err=%b expected 1 %h %b",
                 bus.res_valid, bus.res_data, bus.res_err, ed, ee);
      end
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.vec_a !== ea || bus.vec_b !== eb) begin
        miscompares++;
        $display("FAIL hold_vectors: in_ready=%b vec_a=%h expected 0 %h",
                 bus.in_ready, bus.vec_a, ea);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.sim_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: res_valid=%b in_ready=%b expected 0 1",
               bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (bus.start !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_err !== 1'b0 ||
        bus.res_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: start=%b valid=%b err=%b data=%h expected zeros",
               bus.start, bus.res_valid, bus.res_err, bus.res_data);
    end
    vectors++;
    if (bus.vec_a !== '0 || bus.vec_b !== '0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_vectors: vec_a=%h vec_b=%h in_ready=%b expected 0 0 1",
               bus.vec_a, bus.vec_b, bus.in_ready);
    end
    for (int i = 0; i < W; i++) begin
      mdl_a[i] = 32'h0;
      mdl_b[i] = 32'h0;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int s0, lat;
    logic [31:0] ones [W];
    ones = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    for (int i = 0; i < W; i++) begin
      stim[i]     = ones[i];
      stim[i + W] = ones[i];
    end
    s0 = start_cnt;
    feed(2*W, 1'b0);
    vectors++;
    if (bus.start !== 1'b1 || start_cnt != s0) begin
      miscompares++;
      $display("FAIL dir_start: start=%b pulses=%0d expected 1 %0d", bus.start, start_cnt, s0);
    end
    vectors++;
    if (bus.vec_a !== exp_vec(1'b0) || bus.vec_b !== exp_vec(1'b1) || exp_vec(1'b0) != exp_vec(1'b1)) begin
      miscompares++;
      $display("FAIL dir_vectors: vec_a=%h vec_b=%h", bus.vec_a, bus.vec_b);
    end
    bus.res_ready = 1'b1;
    await_result(7, 1'b1, 32'h3F800000, lat);
    vectors++;
    if (lat != 8 || bus.res_data !== 32'h3F800000 || bus.res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL dir_result: lat=%0d data=%h err=%b expected 8 3f800000 0",
               lat, bus.res_data, bus.res_err);
    end
    tick();
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || start_cnt != s0 + 1) begin
      miscompares++;
      $display("FAIL dir_after: valid=%b in_ready=%b pulses=%0d expected 0 1 %0d",
               bus.res_valid, bus.in_ready, start_cnt, s0 + 1);
    end
  endtask

  task automatic test_timeout();
    int lat;
    new_stim();
    feed(2*W, 1'b1);
    await_result(0, 1'b0, 32'h0, lat);
    vectors++;
    if (lat != TIMEOUT + 1 || bus.res_data !== 32'h0 || bus.res_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: lat=%0d data=%h err=%b expected %0d 0 1",
               lat, bus.res_data, bus.res_err, TIMEOUT + 1);
    end
    drain(2, 32'h0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] val;
    val = $urandom;
    new_stim();
    feed(2*W, 1'b0);
    await_result(3, 1'b1, val, lat);
    vectors++;
    if (lat != 4 || bus.res_data !== val || bus.res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_result: lat=%0d data=%h err=%b expected 4 %h 0",
               lat, bus.res_data, bus.res_err, val);
    end
    drain(20, val, 1'b0);
  endtask

  task automatic test_flush();
    int s0, lat;
    logic [31:0] val;
    new_stim();
    feed(6, 1'b0);
    vectors++;
    if (bus.vec_a !== exp_vec(1'b0) || bus.vec_b !== exp_vec(1'b1)) begin
      miscompares++;
      $display("FAIL flush_partial: vec_b=%h expected %h", bus.vec_b, exp_vec(1'b1));
    end
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: in_ready=%b expected 0", bus.in_ready);
    end
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (bus.start !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.vec_a !== exp_vec(1'b0) || bus.vec_b !== exp_vec(1'b1)) begin
      miscompares++;
      $display("FAIL flush_state: start=%b valid=%b in_ready=%b vec_b=%h expected 0 0 1 %h",
               bus.start, bus.res_valid, bus.in_ready, bus.vec_b, exp_vec(1'b1));
    end
    new_stim();
    s0 = start_cnt;
    feed(2*W, 1'b0);
    vectors++;
    if (bus.start !== 1'b1 || bus.vec_a !== exp_vec(1'b0) || bus.vec_b !== exp_vec(1'b1)) begin
      miscompares++;
      $display("FAIL flush_reload: start=%b vec_a=%h expected 1 %h",
               bus.start, bus.vec_a, exp_vec(1'b0));
    end
    val = $urandom;
    await_result(2, 1'b1, val, lat);
    vectors++;
    if (lat != 3 || bus.res_data !== val || start_cnt != s0 + 1) begin
      miscompares++;
      $display("FAIL flush_result: lat=%0d data=%h pulses=%0d expected 3 %h %0d",
               lat, bus.res_data, start_cnt, val, s0 + 1);
    end
    // Flush in OUT discards the pending result but keeps res_data.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== val || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_out: valid=%b data=%h in_ready=%b expected 0 %h 1",
               bus.res_valid, bus.res_data, bus.in_ready, val);
    end
  endtask

  task automatic test_reset_mid_wait();
    int s0, lat;
    logic [31:0] val;
    new_stim();
    feed(2*W, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < W; i++) begin
      mdl_a[i] = 32'h0;
      mdl_b[i] = 32'h0;
    end
    vectors++;
    if (bus.start !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 ||
        bus.res_err !== 1'b0 || bus.vec_a !== '0 || bus.vec_b !== '0) begin
      miscompares++;
      $display("FAIL rst_wait: start=%b valid=%b data=%h vec_a=%h expected zeros",
               bus.start, bus.res_valid, bus.res_data, bus.vec_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    for (int j = 0; j < 10; j++) begin
      bus.sim_valid      = 1'($urandom_range(0, 1));
      bus.sim_similarity = $urandom;
      tick();
      vectors++;
      if (bus.res_valid !== 1'b0 || bus.start !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_quiet: valid=%b start=%b expected 0 0", bus.res_valid, bus.start);
      end
    end
    bus.sim_valid = 1'b0;
    new_stim();
    feed(2*W, 1'b0);
    vectors++;
    if (bus.start !== 1'b1 || start_cnt != s0 || bus.vec_a !== exp_vec(1'b0) ||
        bus.vec_b !== exp_vec(1'b1)) begin
      miscompares++;
      $display("FAIL rst_reload: start=%b pulses=%0d expected 1 %0d", bus.start, start_cnt, s0);
    end
    val = $urandom;
    await_result(5, 1'b1, val, lat);
    vectors++;
    if (lat != 6 || bus.res_data !== val || bus.res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_result: lat=%0d data=%h expected 6 %h", lat, bus.res_data, val);
    end
    drain(1, val, 1'b0);
  endtask

  // Mode 0: early answer, 1: answer on the timeout cycle, 2: no answer.
  task automatic test_random();
    int mode, d, lat, s0, exp_lat;
    logic [31:0] val, exp_data;
    logic exp_err;
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 2);
      d    = (mode == 0) ? $urandom_range(1, TIMEOUT - 1) : TIMEOUT;
      val  = $urandom;
      new_stim();
      s0 = start_cnt;
      feed(2*W, 1'b1);
      vectors++;
      if (bus.start !== 1'b1 || bus.vec_a !== exp_vec(1'b0) || bus.vec_b !== exp_vec(1'b1)) begin
        miscompares++;
        $display("FAIL rnd_load it=%0d: start=%b vec_b=%h expected 1 %h",
                 it, bus.start, bus.vec_b, exp_vec(1'b1));
      end
      await_result(d, mode != 2, val, lat);
      exp_lat  = (mode != 2) ? d + 1 : TIMEOUT + 1;
      exp_data = (mode != 2) ? val : 32'h0;
      exp_err  = (mode == 2);
      vectors++;
      if (lat != exp_lat || bus.res_data !== exp_data || bus.res_err !== exp_err ||
          start_cnt != s0 + 1) begin
        miscompares++;
        $display("FAIL rnd_result it=%0d mode=%0d: lat=%0d data=%h err=%b expected %0d %h %b",
                 it, mode, lat, bus.res_data, bus.res_err, exp_lat, exp_data, exp_err);
      end
      drain($urandom_range(0, 3), exp_data, exp_err);
    end
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_data        = 32'h0;
    bus.sim_valid      = 1'b0;
    bus.sim_similarity = 32'h0;
    bus.res_ready      = 1'b0;
    test_reset();
    test_directed();
    test_timeout();
    test_backpressure();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
